rom_sample_player: RTL and testbench

//  Multi-channel wavetable/sample playback engine for the audio path.

---
 rtl/rom_sample_player_if.sv | 31 +++
 rtl/rom_sample_player.sv | 200 ++++++++++++++++++++
 tb/tb_rom_sample_player.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_sample_player_if.sv
// Bundle of the config, trigger, ROM and mix-output signals of rom_sample_player.
// master = controller/ROM side, slave = the player.
interface rom_sample_player_if #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 16
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_sel;
  logic [15:0]         cfg_wdata;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] busy;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_data;
  logic [OUT_W-1:0]    sample_out;
  logic                sample_valid;

  modport master (
    output cfg_we, cfg_ch, cfg_sel, cfg_wdata, trig, rom_data,
    input  busy, rom_addr, sample_out, sample_valid
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_sel, cfg_wdata, trig, rom_data,
    output busy, rom_addr, sample_out, sample_valid
  );
endinterface

// File: rtl/rom_sample_player.sv
// Time-multiplexed wavetable player: CHANNELS voices share one sync-read ROM, mixed once per frame.
// Define ROM_SAMPLE_PLAYER_VOLUME_EN to build the per-voice 4-bit volume multipliers.
module rom_sample_player #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 8,
  parameter int TICK_DIV = 64,
  parameter int OUT_W    = 16
) (
  input logic clk,
  input logic rst,
  rom_sample_player_if.slave bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int POS_W = ADDR_W + FRAC_W;
  localparam int EXT_W = ((POS_W > 16) ? POS_W : 16) + 1;
  localparam int CTR_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
  localparam int MIX_W = DATA_W + 4 + $clog2(CHANNELS);
`else
  localparam int MIX_W = DATA_W + $clog2(CHANNELS);
`endif

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                drain_q, drain_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic                fetch_en, fetch_last;
  logic [ADDR_W-1:0]   pos_int [CHANNELS];
  logic [CHANNELS-1:0] busy_vec;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                p1_vld_q, p1_last_q, p1_busy_q;
  logic                p2_vld_q, p2_last_q, p2_busy_q;
  logic [MIX_W-1:0]    acc_q, contrib;
  logic [OUT_W-1:0]    sample_out_q;
  logic                sample_valid_q;
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
  logic [3:0]          vol_arr [CHANNELS];
  logic [3:0]          p1_vol_q, p2_vol_q;
  logic [DATA_W+3:0]   prod;
`endif

  assign ctr_d      = (ctr_q == CTR_W'(TICK_DIV - 1)) ? '0 : ctr_q + CTR_W'(1);
  assign fetch_last = (ch_q == CH_W'(CHANNELS - 1));

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    drain_d  = drain_q;
    fetch_en = 1'b0;
    case (state_q)
      IDLE: if (ctr_q == '0) begin
        state_d = FETCH;
        ch_d    = '0;
      end
      FETCH: begin
        fetch_en = 1'b1;
        if (fetch_last) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q) state_d = IDLE;
        drain_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_voice
    logic [ADDR_W-1:0] start_q, end_q;
    logic [15:0]       step_q;
    logic              en_q, loop_q, busy_q;
    logic [POS_W-1:0]  pos_q;
    logic              wr, fetch_me, overrun;
    logic [EXT_W-1:0]  sum;
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
    logic [3:0]        vol_q;
    assign vol_arr[gi] = vol_q;
`endif

    assign wr       = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));
    assign fetch_me = fetch_en && (ch_q == CH_W'(gi));
    assign sum      = EXT_W'(pos_q) + EXT_W'(step_q);
    // Overrun is either a wrap of the phase register or stepping past the window end.
    assign overrun  = (|sum[EXT_W-1:POS_W]) || (sum[POS_W-1:FRAC_W] > end_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        start_q <= '0;
        end_q   <= '0;
        step_q  <= '0;
        en_q    <= 1'b0;
        loop_q  <= 1'b0;
        busy_q  <= 1'b0;
        pos_q   <= '0;
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
        vol_q   <= '0;
`endif
      end else begin
        if (wr) begin
          case (bus.cfg_sel)
            2'd0:    start_q <= bus.cfg_wdata[ADDR_W-1:0];
            2'd1:    end_q   <= bus.cfg_wdata[ADDR_W-1:0];
            2'd2:    step_q  <= bus.cfg_wdata;
            default: begin
              en_q   <= bus.cfg_wdata[0];
              loop_q <= bus.cfg_wdata[1];
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
              vol_q  <= bus.cfg_wdata[7:4];
`endif
              if (!bus.cfg_wdata[0]) busy_q <= 1'b0;
            end
          endcase
        end
        if (fetch_me && busy_q) begin
          if (!overrun)    pos_q  <= sum[POS_W-1:0];
          else if (loop_q) pos_q  <= {start_q, {FRAC_W{1'b0}}};
          else             busy_q <= 1'b0;
        end
        // Placed last so a trigger overrides any advance or stop in the same cycle.
        if (bus.trig[gi] && en_q) begin
          pos_q  <= {start_q, {FRAC_W{1'b0}}};
          busy_q <= 1'b1;
        end
      end
    end

    assign pos_int[gi]  = pos_q[POS_W-1:FRAC_W];
    assign busy_vec[gi] = busy_q;
  end

`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
  assign prod    = {4'b0, bus.rom_data} * {{DATA_W{1'b0}}, p2_vol_q};
  assign contrib = p2_busy_q ? MIX_W'(prod) : '0;
`else
  assign contrib = p2_busy_q ? MIX_W'(bus.rom_data) : '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      drain_q        <= 1'b0;
      ctr_q          <= '0;
      rom_addr_q     <= '0;
      p1_vld_q       <= 1'b0;
      p1_last_q      <= 1'b0;
      p1_busy_q      <= 1'b0;
      p2_vld_q       <= 1'b0;
      p2_last_q      <= 1'b0;
      p2_busy_q      <= 1'b0;
      acc_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
      p1_vol_q       <= '0;
      p2_vol_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      drain_q        <= drain_d;
      ctr_q          <= ctr_d;
      sample_valid_q <= 1'b0;
      if (fetch_en) rom_addr_q <= pos_int[ch_q];
      // Busy/volume are captured at fetch and ride along with the 2-cycle ROM latency.
      p1_vld_q  <= fetch_en;
      p1_last_q <= fetch_last;
      p1_busy_q <= busy_vec[ch_q];
      p2_vld_q  <= p1_vld_q;
      p2_last_q <= p1_last_q;
      p2_busy_q <= p1_busy_q;
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
      p1_vol_q  <= vol_arr[ch_q];
      p2_vol_q  <= p1_vol_q;
`endif
      if (p2_vld_q) begin
        if (p2_last_q) begin
          acc_q          <= '0;
          sample_out_q   <= OUT_W'(acc_q + contrib);
          sample_valid_q <= 1'b1;
        end else begin
          acc_q <= acc_q + contrib;
        end
      end
    end
  end

  assign bus.busy         = busy_vec;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.sample_out   = sample_out_q;
  assign bus.sample_valid = sample_valid_q;
endmodule

// File: tb/tb_rom_sample_player.sv
// Bench for rom_sample_player: directed vector table, reset corner case, then randomized
// config/trigger traffic against a frame-level reference model.
module tb_rom_sample_player;
  localparam int CHANNELS = 2;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int FRAC_W   = 8;
  localparam int TICK_DIV = 16;
  localparam int OUT_W    = 16;
  localparam int NFR      = 10;
  localparam int NVEC     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_sample_player_if #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  rom_sample_player #(
    .CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FRAC_W(FRAC_W), .TICK_DIV(TICK_DIV), .OUT_W(OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rom_mem [256];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  int checks   = 0;
  int failures = 0;

  // Frame-level reference model.
  int m_start [CHANNELS];
  int m_end   [CHANNELS];
  int m_step  [CHANNELS];
  int m_en    [CHANNELS];
  int m_loop  [CHANNELS];
  int m_vol   [CHANNELS];
  int m_pos   [CHANNELS];
  int m_busy  [CHANNELS];

  function automatic void model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_start[c] = 0; m_end[c] = 0; m_step[c] = 0; m_en[c] = 0;
      m_loop[c] = 0; m_vol[c] = 0; m_pos[c] = 0; m_busy[c] = 0;
    end
  endfunction

  function automatic void model_write(input int ch, input int sel, input int data);
    case (sel)
      0: m_start[ch] = data & 255;
      1: m_end[ch]   = data & 255;
      2: m_step[ch]  = data & 16'hFFFF;
      default: begin
        m_en[ch]   = data & 1;
        m_loop[ch] = (data >> 1) & 1;
        m_vol[ch]  = (data >> 4) & 15;
        if (m_en[ch] == 0) m_busy[ch] = 0;
      end
    endcase
  endfunction

  function automatic void model_trig(input int mask);
    for (int c = 0; c < CHANNELS; c++)
      if (((mask >> c) & 1) == 1 && m_en[c] == 1) begin
        m_pos[c]  = m_start[c] * 256;
        m_busy[c] = 1;
      end
  endfunction

  function automatic int model_busy();
    int m = 0;
    for (int c = 0; c < CHANNELS; c++) m = m | (m_busy[c] << c);
    return m;
  endfunction

  // Expected mix of the next frame, then every playing voice takes one step.
  function automatic int model_frame();
    int sum = 0;
    int nxt;
    for (int c = 0; c < CHANNELS; c++) begin
      if (m_busy[c] == 1) begin
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
        sum += int'(rom_mem[m_pos[c] / 256]) * m_vol[c];
`else
        sum += int'(rom_mem[m_pos[c] / 256]);
`endif
        nxt = m_pos[c] + m_step[c];
        if (nxt > 16'hFFFF || (nxt / 256) > m_end[c]) begin
          if (m_loop[c] == 1) m_pos[c] = m_start[c] * 256;
          else                m_busy[c] = 0;
        end else begin
          m_pos[c] = nxt;
        end
      end
    end
    return sum;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_we = 1'b0;
    bus.trig   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    bus.cfg_ch    = 1'(ch);
    bus.cfg_sel   = 2'(sel);
    bus.cfg_wdata = 16'(data);
    bus.cfg_we    = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    model_write(ch, sel, data);
  endtask

  task automatic pulse_trig(input int mask);
    bus.trig = CHANNELS'(mask);
    @(negedge clk);
    bus.trig = '0;
    model_trig(mask);
  endtask

  task automatic wait_valid(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      @(negedge clk);
      n++;
      if (bus.sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic frame_check(input string name);
    bit ok;
    int n;
    int exp;
    wait_valid(ok, n);
    exp = model_frame();
    if (!ok) begin
      check({name, " timeout"}, 0, 1);
    end else begin
      check(name, int'(bus.sample_out), exp);
      check({name, " busy"}, int'(bus.busy), model_busy());
    end
  endtask

  typedef struct packed {
    logic [7:0]             s0, e0;
    logic [15:0]            st0, c0;
    logic                   use1;
    logic [7:0]             s1, e1;
    logic [15:0]            st1, c1;
    logic [1:0]             trig;
    logic [0:NFR-1][15:0]   exp_on;
    logic [0:NFR-1][15:0]   exp_off;
    logic [1:0]             busy_end;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    bit ok;
    int n;
    int exp;
    string nm;

    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_sel = '0; bus.cfg_wdata = '0; bus.trig = '0;

    vecs[0] = '{s0: 8'h10, e0: 8'h13, st0: 16'h0100, c0: 16'h00F1, use1: 1'b0,
                s1: 8'h00, e1: 8'h00, st1: 16'h0000, c1: 16'h0000, trig: 2'b01,
                exp_on:  {16'd240, 16'd255, 16'd270, 16'd285, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                exp_off: {16'd16, 16'd17, 16'd18, 16'd19, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                busy_end: 2'b00};
    vecs[1] = '{s0: 8'h10, e0: 8'h13, st0: 16'h0080, c0: 16'h00F3, use1: 1'b0,
                s1: 8'h00, e1: 8'h00, st1: 16'h0000, c1: 16'h0000, trig: 2'b01,
                exp_on:  {16'd240, 16'd240, 16'd255, 16'd255, 16'd270, 16'd270, 16'd285, 16'd285, 16'd240, 16'd240},
                exp_off: {16'd16, 16'd16, 16'd17, 16'd17, 16'd18, 16'd18, 16'd19, 16'd19, 16'd16, 16'd16},
                busy_end: 2'b01};
    vecs[2] = '{s0: 8'h10, e0: 8'h13, st0: 16'h0100, c0: 16'h0011, use1: 1'b1,
                s1: 8'h20, e1: 8'hFF, st1: 16'h0000, c1: 16'h0021, trig: 2'b11,
                exp_on:  {16'd80, 16'd81, 16'd82, 16'd83, 16'd64, 16'd64, 16'd64, 16'd64, 16'd64, 16'd64},
                exp_off: {16'd48, 16'd49, 16'd50, 16'd51, 16'd32, 16'd32, 16'd32, 16'd32, 16'd32, 16'd32},
                busy_end: 2'b10};
    vecs[3] = '{s0: 8'hFD, e0: 8'hFF, st0: 16'h0300, c0: 16'h00F1, use1: 1'b0,
                s1: 8'h00, e1: 8'h00, st1: 16'h0000, c1: 16'h0000, trig: 2'b01,
                exp_on:  {16'd3795, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                exp_off: {16'd253, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                busy_end: 2'b00};
    vecs[4] = '{s0: 8'h30, e0: 8'h20, st0: 16'h0100, c0: 16'h00F1, use1: 1'b0,
                s1: 8'h00, e1: 8'h00, st1: 16'h0000, c1: 16'h0000, trig: 2'b01,
                exp_on:  {16'd720, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                exp_off: {16'd48, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                busy_end: 2'b00};

    // Directed vectors
    for (int t = 0; t < NVEC; t++) begin
      do_reset();
      wait_valid(ok, n);
      check($sformatf("vec%0d reset frame valid", t), int'(ok), 1);
      check($sformatf("vec%0d reset frame sample", t), int'(bus.sample_out), 0);
      cfg_write(0, 0, int'(vecs[t].s0));
      cfg_write(0, 1, int'(vecs[t].e0));
      cfg_write(0, 2, int'(vecs[t].st0));
      cfg_write(0, 3, int'(vecs[t].c0));
      if (vecs[t].use1) begin
        cfg_write(1, 0, int'(vecs[t].s1));
        cfg_write(1, 1, int'(vecs[t].e1));
        cfg_write(1, 2, int'(vecs[t].st1));
        cfg_write(1, 3, int'(vecs[t].c1));
      end
      pulse_trig(int'(vecs[t].trig));
      check($sformatf("vec%0d busy after trig", t), int'(bus.busy), int'(vecs[t].trig));
      for (int f = 0; f < NFR; f++) begin
        wait_valid(ok, n);
`ifdef ROM_SAMPLE_PLAYER_VOLUME_EN
        exp = int'(vecs[t].exp_on[f]);
`else
        exp = int'(vecs[t].exp_off[f]);
`endif
        nm = $sformatf("vec%0d frame%0d", t, f);
        if (!ok) check({nm, " timeout"}, 0, 1);
        else     check(nm, int'(bus.sample_out), exp);
      end
      check($sformatf("vec%0d busy at end", t), int'(bus.busy), int'(vecs[t].busy_end));
    end

    // Asynchronous reset in the middle of a fetch, then frame restart timing
    do_reset();
    wait_valid(ok, n);
    cfg_write(0, 0, 8'h10);
    cfg_write(0, 1, 8'h13);
    cfg_write(0, 2, 16'h0080);
    cfg_write(0, 3, 16'h00F3);
    pulse_trig(1);
    wait_valid(ok, n);
    check("pre-reset busy", int'(bus.busy), 1);
    repeat (TICK_DIV - 3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst sample_out", int'(bus.sample_out), 0);
    check("async rst busy", int'(bus.busy), 0);
    check("async rst rom_addr", int'(bus.rom_addr), 0);
    check("async rst sample_valid", int'(bus.sample_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_valid(ok, n);
    check("restart valid latency", ok ? n : -1, CHANNELS + 3);
    check("restart sample", int'(bus.sample_out), 0);
    @(negedge clk);
    check("valid pulse width", int'(bus.sample_valid), 0);
    wait_valid(ok, n);
    check("frame period", ok ? n + 1 : -1, TICK_DIV);

    // Randomized traffic against the model
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    do_reset();
    frame_check("rand frame init");
    for (int f = 0; f < 60; f++) begin
      int nops;
      nops = int'($urandom_range(0, 4));
      for (int k = 0; k < nops; k++) begin
        int kind, ch, d;
        kind = int'($urandom_range(0, 5));
        ch   = int'($urandom_range(0, CHANNELS - 1));
        case (kind)
          0, 1: d = int'($urandom_range(0, 255));
          2:    d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16'h0300));
          3:    d = int'(($urandom & 32'h00F2) | (($urandom_range(0, 3) != 0) ? 1 : 0));
          default: d = int'($urandom_range(1, 3));
        endcase
        if (kind < 4) cfg_write(ch, kind, d);
        else          pulse_trig(d);
      end
      frame_check($sformatf("rand frame%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
